// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat deal sequencer: state encoding,
// score width and the drawing thresholds used by the round controller.
package baccarat_pkg;

    localparam int SCORE_W = 4;
    localparam logic [SCORE_W-1:0] NATURAL   = 4'd8;
    localparam logic [SCORE_W-1:0] DRAW_MAX  = 4'd5;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        P1        = 4'd1,
        D1        = 4'd2,
        P2        = 4'd3,
        D2        = 4'd4,
        EVAL      = 4'd5,
        P3        = 4'd6,
        BANK_EVAL = 4'd7,
        D3        = 4'd8,
        SETTLE    = 4'd9,
        RESULT    = 4'd10
    } deal_state_t;

endpackage

// File: rtl/third_card_rule.sv
// Banker third-card table: decides whether the dealer draws given the
// dealer's two-card total and the player's third card.
module third_card_rule
    import baccarat_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pcard3,
    output logic               draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pcard3 != 4'd8);
            4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round controller: requests cards, steers them into the datapath
// card registers and registers the result lights. Optional win tallies
// are built when DEAL_TALLY_EN is defined.
//
// Handshake: card_req is high in every deal state; a card is consumed on a
// rising edge where card_req and card_ack are both high, and the matching
// load enable is card_req & card_ack so the card register loads on that edge.
module deal_sequencer
    import baccarat_pkg::*;
(
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               start,
    input  logic               card_ack,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pcard3,
    output logic               card_req,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light,
    output logic               busy,
    output logic               done,
`ifdef DEAL_TALLY_EN
    output logic [7:0]         p_wins,
    output logic [7:0]         d_wins,
    output logic [7:0]         ties,
`endif
    output logic [3:0]         state_dbg
);

    deal_state_t state, next_state;
    logic        banker_draw;
    logic        take;
    logic        enter_result;
    logic        restart;

    third_card_rule u_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    assign state_dbg = state;
    assign take      = card_req & card_ack;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESULT: if (start) next_state = P1;
            P1:           if (card_ack) next_state = D1;
            D1:           if (card_ack) next_state = P2;
            P2:           if (card_ack) next_state = D2;
            D2:           if (card_ack) next_state = EVAL;
            EVAL: begin
                if (pscore >= NATURAL || dscore >= NATURAL) next_state = RESULT;
                else if (pscore <= DRAW_MAX)                 next_state = P3;
                else if (dscore <= DRAW_MAX)                 next_state = D3;
                else                                         next_state = RESULT;
            end
            P3:           if (card_ack) next_state = BANK_EVAL;
            BANK_EVAL:    next_state = banker_draw ? D3 : RESULT;
            D3:           if (card_ack) next_state = SETTLE;
            SETTLE:       next_state = RESULT;
            default:      next_state = IDLE;
        endcase
    end

    always_comb begin
        card_req    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            P1, D1, P2, D2, P3, D3: card_req = 1'b1;
            IDLE:                   busy     = 1'b0;
            RESULT: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_pcard1 = take && (state == P1);
        load_dcard1 = take && (state == D1);
        load_pcard2 = take && (state == P2);
        load_dcard2 = take && (state == D2);
        load_pcard3 = take && (state == P3);
        load_dcard3 = take && (state == D3);
    end

    assign restart      = start && (state == IDLE || state == RESULT);
    assign enter_result = (next_state == RESULT) && (state != RESULT);

    // Lights capture the final totals on the edge that enters RESULT.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (restart) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (enter_result) begin
            player_win_light <= (pscore >= dscore);
            dealer_win_light <= (dscore >= pscore);
        end
    end

`ifdef DEAL_TALLY_EN
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            p_wins <= 8'd0;
            d_wins <= 8'd0;
            ties   <= 8'd0;
        end else if (enter_result) begin
            if (pscore > dscore) begin
                if (p_wins != 8'hFF) p_wins <= p_wins + 8'd1;
            end else if (dscore > pscore) begin
                if (d_wins != 8'hFF) d_wins <= d_wins + 8'd1;
            end else begin
                if (ties != 8'hFF) ties <= ties + 8'd1;
            end
        end
    end
`endif

endmodule
